// File: rtl/sram_port_arbiter.sv
// Purpose: shares one single-ported SRAM between the fetch (inst) and load/store (data) requesters.
// Latency: grant and SRAM drive are combinational; each accepted request gets its data_ok exactly LAT cycles later.
// Backpressure: addr_ok is withheld from the losing side. Data wins ties until MAX_STREAK back-to-back wins, then inst is forced.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   inst_req/addr -> addr_ok        - fetch request (read only)
//   inst_data_ok/rdata              - fetch response
//   data_req/wr/wstrb/addr/wdata    - load/store request
//   data_addr_ok                    - load/store accepted this cycle
//   data_data_ok/rdata              - load/store response (data_ok also marks store completion)
//   sram_en/wen/addr/wdata/rdata    - SRAM port; the address is word aligned
module sram_port_arbiter #(
    parameter int LAT        = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0]     streak_q, streak_d;
    logic [LAT-1:0] vld_q, vld_d;   // in-flight valid per pipeline stage
    logic [LAT-1:0] own_q, own_d;   // in-flight owner per stage: 0 = inst, 1 = data
    logic           gnt_inst, gnt_data;
    logic           resp_vld;

    // Byte-offset bits never reach the SRAM; this only marks them as deliberately unused.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{inst_addr[1:0], data_addr[1:0]};

    // Grant: data wins a tie unless inst has already waited MAX_STREAK data grants.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (!reset) begin
            if (data_req && !(inst_req && (streak_q == STREAK_MAX))) begin
                gnt_data = 1'b1;
            end else if (inst_req) begin
                gnt_inst = 1'b1;
            end
        end
    end

    assign inst_addr_ok = gnt_inst;
    assign data_addr_ok = gnt_data;

    // SRAM drive straight from the winner; all fields are zero when nothing is granted.
    always_comb begin
        sram_en    = gnt_inst | gnt_data;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (gnt_data) begin
            sram_wen   = data_wr ? data_wstrb : 4'b0000;
            sram_addr  = {data_addr[31:2], 2'b00};
            sram_wdata = data_wdata;
        end else if (gnt_inst) begin
            sram_addr  = {inst_addr[31:2], 2'b00};
        end
    end

    // The streak only counts data wins that actually made inst wait.
    always_comb begin
        streak_d = streak_q;
        if (!inst_req || gnt_inst) begin
            streak_d = 4'd0;
        end else if (gnt_data && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Fixed-length, never-stalling owner pipeline. The SRAM latency is fixed,
    // so the last stage lines up with sram_rdata.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = gnt_inst | gnt_data;
        own_d[0] = gnt_data;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= 4'd0;
            vld_q    <= '0;
            own_q    <= '0;
        end else begin
            streak_q <= streak_d;
            vld_q    <= vld_d;
            own_q    <= own_d;
        end
    end

    assign resp_vld     = vld_q[LAT-1] && !reset;
    assign inst_data_ok = resp_vld && !own_q[LAT-1];
    assign data_data_ok = resp_vld &&  own_q[LAT-1];
    assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one instance with LAT=1 (a_*) and one with LAT=3 (b_*).
// Both instances share the request inputs. Each instance has its own behavioural SRAM.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok, a_sram_en;
    logic [31:0] a_inst_rdata, a_data_rdata, a_sram_addr, a_sram_wdata, a_sram_rdata;
    logic [3:0]  a_sram_wen;
    logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_sram_en;
    logic [31:0] b_inst_rdata, b_data_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;
    logic [3:0]  b_sram_wen;

    int errors = 0;
    int checks = 0;

    // Starvation table: inst_req per step, with data_req held at 1 throughout.
    // Expected winner per step: 1 = data, 0 = inst.
    bit seq_i [18] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1,1};
    bit seq_g [18] = '{1,1,1,1,0,1,1,1,1,0,1,1,1,1,1,1,1,0};

    always #5 clk = ~clk;

    sram_port_arbiter #(.LAT(1), .MAX_STREAK(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
        .sram_en(a_sram_en), .sram_wen(a_sram_wen), .sram_addr(a_sram_addr),
        .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata)
    );

    sram_port_arbiter #(.LAT(3), .MAX_STREAK(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
        .sram_en(b_sram_en), .sram_wen(b_sram_wen), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
    );

    // Behavioural SRAMs: word = {A5A5, index} except word 1, byte-write merge,
    // read data delayed by LAT cycles. A junk value appears when the port is idle.
    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];
    logic [31:0] rd_a;
    logic [31:0] rd_b [3];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] <= {16'hA5A5, 4'h0, 12'(i)};
            mem_b[i] <= {16'hA5A5, 4'h0, 12'(i)};
        end
        mem_a[1] <= 32'h24080001;
        mem_b[1] <= 32'h24080001;
    end

    always @(posedge clk) begin
        if (a_sram_en) begin
            rd_a <= mem_a[a_sram_addr[13:2]];
            for (int k = 0; k < 4; k++)
                if (a_sram_wen[k]) mem_a[a_sram_addr[13:2]][k*8 +: 8] <= a_sram_wdata[k*8 +: 8];
        end else begin
            rd_a <= 32'hDEADBEEF;
        end
    end
    assign a_sram_rdata = rd_a;

    always @(posedge clk) begin
        if (b_sram_en) begin
            rd_b[0] <= mem_b[b_sram_addr[13:2]];
            for (int k = 0; k < 4; k++)
                if (b_sram_wen[k]) mem_b[b_sram_addr[13:2]][k*8 +: 8] <= b_sram_wdata[k*8 +: 8];
        end else begin
            rd_b[0] <= 32'hDEADBEEF;
        end
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign b_sram_rdata = rd_b[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    initial begin
        // Reset with both requests raised: nothing may be granted.
        idle_inputs();
        reset      = 1'b1;
        inst_req   = 1'b1;
        inst_addr  = 32'h2000;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'hF;
        data_addr  = 32'h1000;
        @(negedge clk); #1;
        chk("rst_inst_addr_ok", a_inst_addr_ok, 0);
        chk("rst_data_addr_ok", a_data_addr_ok, 0);
        chk("rst_sram_en",      a_sram_en, 0);
        chk("rst_sram_wen",     a_sram_wen, 0);
        chk("rst_inst_data_ok", a_inst_data_ok, 0);
        chk("rst_data_data_ok", a_data_data_ok, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        // Single fetch, LAT=1.
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00004;
        #1;
        chk("f_inst_addr_ok", a_inst_addr_ok, 1);
        chk("f_data_addr_ok", a_data_addr_ok, 0);
        chk("f_sram_en",      a_sram_en, 1);
        chk("f_sram_addr",    a_sram_addr, 32'hBFC00004);
        chk("f_sram_wen",     a_sram_wen, 0);
        chk("f_sram_wdata",   a_sram_wdata, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("f_inst_data_ok", a_inst_data_ok, 1);
        chk("f_inst_rdata",   a_inst_rdata, 32'h24080001);
        chk("f_data_data_ok", a_data_data_ok, 0);
        chk("f_idle_sram_en", a_sram_en, 0);
        chk("f_idle_addr",    a_sram_addr, 0);

        // Both requesting: data wins.
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h2000;
        data_req  = 1'b1;
        data_addr = 32'h1000;
        #1;
        chk("tie_data_addr_ok", a_data_addr_ok, 1);
        chk("tie_inst_addr_ok", a_inst_addr_ok, 0);
        chk("tie_sram_addr",    a_sram_addr, 32'h1000);
        chk("tie_sram_wen",     a_sram_wen, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("tie_data_data_ok", a_data_data_ok, 1);
        chk("tie_inst_data_ok", a_inst_data_ok, 0);
        chk("tie_data_rdata",   a_data_rdata, 32'hA5A50400);
        chk("tie_inst_rdata",   a_inst_rdata, 0);

        // Partial store, then read back the merged word.
        @(negedge clk);
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h1003;
        data_wdata = 32'hAABBCCDD;
        #1;
        chk("st_addr_ok",    a_data_addr_ok, 1);
        chk("st_sram_wen",   a_sram_wen, 4'b0011);
        chk("st_sram_addr",  a_sram_addr, 32'h1000);
        chk("st_sram_wdata", a_sram_wdata, 32'hAABBCCDD);
        chk("st_no_resp",    a_data_data_ok, 0);
        chk("st_rdata_zero", a_data_rdata, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("st_data_ok",    a_data_data_ok, 1);
        @(negedge clk);
        data_req  = 1'b1;
        data_addr = 32'h1000;
        #1;
        chk("ld_addr_ok",    a_data_addr_ok, 1);
        chk("ld_sram_wen",   a_sram_wen, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("ld_data_ok",    a_data_data_ok, 1);
        chk("ld_merged",     a_data_rdata, 32'hA5A5CCDD);

        // Starvation guard and streak clearing.
        for (int s = 0; s < 18; s++) begin
            @(negedge clk);
            inst_req  = seq_i[s];
            inst_addr = 32'h2000;
            data_req  = 1'b1;
            data_addr = 32'h1000;
            #1;
            chk("stv_data_gnt", a_data_addr_ok, seq_g[s]);
            chk("stv_inst_gnt", a_inst_addr_ok, !seq_g[s]);
            chk("stv_sram_addr", a_sram_addr, seq_g[s] ? 32'h1000 : 32'h2000);
            if (s > 0) chk("stv_resp_owner", a_data_data_ok, seq_g[s-1]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("stv_last_inst_ok", a_inst_data_ok, 1);
        chk("stv_last_rdata",   a_inst_rdata, 32'hA5A50800);
        repeat (4) @(negedge clk);

        // LAT=3: grants I, D, I on consecutive cycles.
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h2000;
        #1;
        chk("l3_g0_inst_ok", b_inst_addr_ok, 1);
        chk("l3_g0_no_iresp", b_inst_data_ok, 0);
        chk("l3_g0_no_dresp", b_data_data_ok, 0);
        @(negedge clk);
        inst_req  = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h1000;
        #1;
        chk("l3_g1_data_ok", b_data_addr_ok, 1);
        chk("l3_g1_no_iresp", b_inst_data_ok, 0);
        @(negedge clk);
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00004;
        #1;
        chk("l3_g2_inst_ok", b_inst_addr_ok, 1);
        chk("l3_g2_no_dresp", b_data_data_ok, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("l3_r0_inst_ok", b_inst_data_ok, 1);
        chk("l3_r0_rdata",   b_inst_rdata, 32'hA5A50800);
        chk("l3_r0_no_data", b_data_data_ok, 0);
        @(negedge clk); #1;
        chk("l3_r1_data_ok", b_data_data_ok, 1);
        chk("l3_r1_rdata",   b_data_rdata, 32'hA5A5CCDD);
        chk("l3_r1_no_inst", b_inst_data_ok, 0);
        chk("l3_r1_irdata0", b_inst_rdata, 0);
        @(negedge clk); #1;
        chk("l3_r2_inst_ok", b_inst_data_ok, 1);
        chk("l3_r2_rdata",   b_inst_rdata, 32'h24080001);
        @(negedge clk); #1;
        chk("l3_r3_no_inst", b_inst_data_ok, 0);
        chk("l3_r3_no_data", b_data_data_ok, 0);

        // Reset one cycle after a LAT=3 grant discards it.
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'h2000;
        #1;
        chk("mr_grant", b_inst_addr_ok, 1);
        @(negedge clk);
        reset      = 1'b1;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'hF;
        data_addr  = 32'h1000;
        data_wdata = 32'h11223344;
        #1;
        chk("mr_inst_addr_ok", b_inst_addr_ok, 0);
        chk("mr_data_addr_ok", b_data_addr_ok, 0);
        chk("mr_sram_en",      b_sram_en, 0);
        chk("mr_sram_wen",     b_sram_wen, 0);
        chk("mr_sram_addr",    b_sram_addr, 0);
        chk("mr_sram_wdata",   b_sram_wdata, 0);
        chk("mr_inst_data_ok", b_inst_data_ok, 0);
        chk("mr_data_data_ok", b_data_data_ok, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("mr_no_iresp", b_inst_data_ok, 0);
            chk("mr_no_dresp", b_data_data_ok, 0);
        end
        @(negedge clk);
        data_req  = 1'b1;
        data_addr = 32'h1000;
        #1;
        chk("pr_grant", b_data_addr_ok, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("pr_data_ok", b_data_data_ok, (k == 3) ? 1 : 0);
        end
        chk("pr_rdata", b_data_rdata, 32'hA5A5CCDD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
